// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register placed at every stage boundary. Carries a
//   WIDTH-bit payload with a valid/ready handshake, holds the output entry on
//   stall and turns everything it holds into a bubble on flush. Bubbles always
//   present FLUSH_VAL on out_data, so a flushed stage reads as a NOP.
//
//   SKID=1 adds a second (skid) entry so that in_ready is driven from a flop
//   only, breaking the combinational path out_ready -> in_ready.
//   SKID=0 is a single entry with combinational in_ready.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept in_data this cycle
//   in_data    in   WIDTH  upstream payload
//   stall      in   1      hazard hold, output entry does not advance
//   flush      in   1      discard held entries and the current input
//   out_valid  out  1      out_data holds a live entry
//   out_ready  in   1      downstream accepts out_data
//   out_data   out  WIDTH  payload to downstream, FLUSH_VAL when not valid
//   occ        out  2      number of entries held
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int               WIDTH     = 32,
   parameter bit               SKID      = 1'b1,
   parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             stall,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occ
);

   logic             main_v_r;
   logic [WIDTH-1:0] main_d_r;
   logic             skid_v_r;
   logic [WIDTH-1:0] skid_d_r;
   logic [1:0]       occ_r;

   logic             main_v_nxt_s;
   logic [WIDTH-1:0] main_d_nxt_s;
   logic             skid_v_nxt_s;
   logic [WIDTH-1:0] skid_d_nxt_s;
   logic [1:0]       occ_nxt_s;

   logic             adv_s;
   logic             acc_s;
   logic             in_ready_s;

   // stall masks downstream acceptance, so a stalled entry never advances
   assign adv_s = main_v_r & out_ready & ~stall;
   assign acc_s = in_valid & in_ready_s;

   generate
      if (SKID) begin : g_ready_skid
         // Flop-only ready: the skid slot absorbs the one beat that may
         // arrive while downstream back-pressure is still being seen.
         assign in_ready_s = ~skid_v_r;
      end else begin : g_ready_single
         // Single entry: a slot frees up in the same cycle the entry leaves.
         assign in_ready_s = ~main_v_r | adv_s;
      end
   endgenerate

   // Next-state selection for main and skid entries (flush > normal update)
   always_comb begin
      main_v_nxt_s = main_v_r;
      main_d_nxt_s = main_d_r;
      skid_v_nxt_s = skid_v_r;
      skid_d_nxt_s = skid_d_r;
      if (flush) begin
         // Input accepted this cycle is dropped as well; an adv this cycle
         // has already been seen by downstream, which handles its own kill.
         main_v_nxt_s = 1'b0;
         main_d_nxt_s = FLUSH_VAL;
         skid_v_nxt_s = 1'b0;
         skid_d_nxt_s = FLUSH_VAL;
      end else if (~main_v_r | adv_s) begin
         if (skid_v_r) begin
            // Oldest held beat moves up; in_ready was 0 so no acc here.
            main_v_nxt_s = 1'b1;
            main_d_nxt_s = skid_d_r;
            skid_v_nxt_s = 1'b0;
            skid_d_nxt_s = FLUSH_VAL;
         end else if (acc_s) begin
            main_v_nxt_s = 1'b1;
            main_d_nxt_s = in_data;
         end else begin
            // Keep main_d at FLUSH_VAL whenever main is empty, so out_data
            // can be driven straight from the flop.
            main_v_nxt_s = 1'b0;
            main_d_nxt_s = FLUSH_VAL;
         end
      end else begin
         if (SKID && acc_s) begin
            skid_v_nxt_s = 1'b1;
            skid_d_nxt_s = in_data;
         end else begin
            skid_v_nxt_s = skid_v_r;
            skid_d_nxt_s = skid_d_r;
         end
      end
      occ_nxt_s = {1'b0, main_v_nxt_s} + {1'b0, skid_v_nxt_s};
   end

   // Entry and occupancy registers, async reset to an empty stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_v_r <= 1'b0;
         main_d_r <= FLUSH_VAL;
         skid_v_r <= 1'b0;
         skid_d_r <= FLUSH_VAL;
         occ_r    <= 2'd0;
      end else begin
         main_v_r <= main_v_nxt_s;
         main_d_r <= main_d_nxt_s;
         skid_v_r <= skid_v_nxt_s;
         skid_d_r <= skid_d_nxt_s;
         occ_r    <= occ_nxt_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = main_v_r;
   assign out_data  = main_d_r;
   assign occ       = occ_r;

endmodule
